// File: rtl/riscv_core_cache_pkg.sv
// Shared types and constants for the instruction-cache refill path.
package riscv_core_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE,
        ST_HOLD
    } refill_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         LINE_OFFSET_W  = 5;

endpackage

// File: rtl/riscv_core_refill_line_assembler.sv
// Beat counter plus line register: drops each accepted R beat into its lane, beat 0 lowest.
module riscv_core_refill_line_assembler #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              beat_accept,
    input  logic [BEAT_W-1:0] beat_data,
    output logic [LINE_W-1:0] line,
    output logic              count_done
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CNT_W-1:0] beat_cnt;

    assign count_done = beat_accept && (beat_cnt == CNT_W'(BEATS - 1));

    // The line is not cleared on a new burst so the cache sees a stable block until the first new beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            line     <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
        end else if (beat_accept) begin
            line[beat_cnt*BEAT_W +: BEAT_W] <= beat_data;
            beat_cnt                        <= beat_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/riscv_core_icache_axi_refill.sv
// Icache refill responder: one AXI4 INCR read burst per miss, assembled into a full line.
// Optional o_refill_err output when ICACHE_REFILL_ERR_EN is defined.
//
// state | meaning
// IDLE  | waiting for a refill request
// ADDR  | AR valid, waiting for arready
// DATA  | accepting R beats until the line is full
// DONE  | one-cycle line-valid pulse to the cache
// HOLD  | one dead cycle while the cache drops its request
module riscv_core_icache_axi_refill
    import riscv_core_cache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int AXI_DATA_WIDTH = 256,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int ID_WIDTH       = 4,
    parameter int AXI_ID         = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_mem_req,
    input  logic [ADDR_WIDTH-1:0]     i_addr_from_control,
    output logic                      o_mem_done,
`ifdef ICACHE_REFILL_ERR_EN
    output logic                      o_refill_err,
`endif
    output logic [AXI_DATA_WIDTH-1:0] o_block_to_cache,
    output logic [ADDR_WIDTH-1:0]     o_araddr,
    output logic                      o_arvalid,
    input  logic                      i_arready,
    output logic [ID_WIDTH-1:0]       o_arid,
    output logic [7:0]                o_arlen,
    output logic [2:0]                o_arsize,
    output logic [1:0]                o_arburst,
    input  logic                      i_rvalid,
    output logic                      o_rready,
    input  logic [BUS_DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]                i_rresp,
    input  logic                      i_rlast
);
    localparam int BEATS = AXI_DATA_WIDTH / BUS_DATA_WIDTH;

    refill_state_t state, next_state;
    logic          start_burst;
    logic          beat_accept;
    logic          last_beat;

    assign o_arid      = ID_WIDTH'(AXI_ID);
    assign o_arlen     = 8'(BEATS - 1);
    assign o_arsize    = 3'($clog2(BUS_DATA_WIDTH / 8));
    assign o_arburst   = AXI_BURST_INCR;

    assign start_burst = (state == ST_IDLE) && i_mem_req;
    assign beat_accept = i_rvalid && o_rready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (i_mem_req) next_state = ST_ADDR;
            ST_ADDR: if (i_arready) next_state = ST_DATA;
            ST_DATA: if (last_beat) next_state = ST_DONE;
            ST_DONE: next_state = ST_HOLD;
            ST_HOLD: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_arvalid  = 1'b0;
        o_rready   = 1'b0;
        o_mem_done = 1'b0;
        case (state)
            ST_ADDR: o_arvalid  = 1'b1;
            ST_DATA: o_rready   = 1'b1;
            ST_DONE: o_mem_done = 1'b1;
            default: ;
        endcase
    end

    // Burst address is line-aligned and frozen for the whole AR phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)         o_araddr <= '0;
        else if (start_burst) o_araddr <= {i_addr_from_control[ADDR_WIDTH-1:LINE_OFFSET_W],
                                           {LINE_OFFSET_W{1'b0}}};
    end

    riscv_core_refill_line_assembler #(
        .LINE_W (AXI_DATA_WIDTH),
        .BEAT_W (BUS_DATA_WIDTH)
    ) u_line_asm (
        .clk         (i_clk),
        .rst_n       (i_rst_n),
        .clear       (start_burst),
        .beat_accept (beat_accept),
        .beat_data   (i_rdata),
        .line        (o_block_to_cache),
        .count_done  (last_beat)
    );

`ifdef ICACHE_REFILL_ERR_EN
    logic err_q;
    logic beat_err;
    logic unused_addr_bits;

    // Beat count, not rlast, ends the burst; a mismatched rlast is only reported.
    assign beat_err = (i_rresp != AXI_RESP_OKAY) || (i_rlast != last_beat);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                    err_q <= 1'b0;
        else if (start_burst)            err_q <= 1'b0;
        else if (beat_accept && beat_err) err_q <= 1'b1;
    end

    assign o_refill_err     = o_mem_done && err_q;
    assign unused_addr_bits = ^i_addr_from_control[LINE_OFFSET_W-1:0];
`else
    logic unused_inputs;
    assign unused_inputs = ^{i_addr_from_control[LINE_OFFSET_W-1:0], i_rresp, i_rlast};
`endif

endmodule
